// File: rtl/jtframe_bank_arbiter_if.sv
// Signal bundle between four ROM read slots, the bank arbiter and one SDRAM bank port.
// slave: the arbiter side; master: the side that drives slot requests and controller replies.
interface jtframe_bank_arbiter_if #(
    parameter int AW = 22,
    parameter int DW = 32
);
    logic [4*AW-1:0] slot_addr;
    logic [3:0]      slot_cs;
    logic [3:0]      slot_ok;
    logic [4*DW-1:0] slot_dout;
    logic [AW-1:0]   sdram_addr;
    logic            sdram_rd;
    logic            sdram_ack;
    logic            sdram_rdy;
    logic [DW-1:0]   sdram_dout;

    modport slave (
        input  slot_addr, slot_cs, sdram_ack, sdram_rdy, sdram_dout,
        output slot_ok, slot_dout, sdram_addr, sdram_rd
    );

    modport master (
        output slot_addr, slot_cs, sdram_ack, sdram_rdy, sdram_dout,
        input  slot_ok, slot_dout, sdram_addr, sdram_rd
    );
endinterface

// File: rtl/jtframe_bank_arbiter.sv
// Four ROM read slots, each with a one-word cache, sharing one SDRAM bank port round-robin.
// Define JTFRAME_BANK_ARB_FLUSH_EN to add a flush input that invalidates every slot cache.
module jtframe_bank_arbiter #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic clk,
    input  logic rst,
`ifdef JTFRAME_BANK_ARB_FLUSH_EN
    input  logic flush,
`endif
    jtframe_bank_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      last_reg;
    logic [AW-1:0]   req_addr_reg;
    logic            sdram_rd_reg;
    logic [3:0]      miss, eligible;
    logic            grant_any;
    logic [1:0]      grant_idx;
    logic [AW-1:0]   grant_addr;
    logic            load_req, fill_en, rd_next;
    logic            flush_now, fill_keep;

`ifdef JTFRAME_BANK_ARB_FLUSH_EN
    // A fetch issued before a flush still finishes on the bus, but its word must not land.
    logic discard_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            discard_reg <= 1'b0;
        else if (load_req)
            discard_reg <= 1'b0;
        else if (flush && state_reg != IDLE)
            discard_reg <= 1'b1;
    end

    assign flush_now = flush;
    assign fill_keep = fill_en & ~flush & ~discard_reg;
`else
    assign flush_now = 1'b0;
    assign fill_keep = fill_en;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi);
            logic [AW-1:0] tag_reg;
            logic [DW-1:0] data_reg;
            logic          valid_reg;
            logic          pend_reg;
            logic          hit;

            assign hit      = bus.slot_cs[gi] & valid_reg & (bus.slot_addr[gi*AW +: AW] == tag_reg);
            assign miss[gi] = bus.slot_cs[gi] & ~hit;
            // A stale pend (miss already gone, e.g. just filled) must never win a grant.
            assign eligible[gi] = pend_reg & miss[gi] & ~flush_now;
            assign bus.slot_ok[gi] = hit;
            assign bus.slot_dout[gi*DW +: DW] = data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_reg   <= '0;
                    data_reg  <= '0;
                    valid_reg <= 1'b0;
                    pend_reg  <= 1'b0;
                end else begin
                    pend_reg <= miss[gi] & ~(load_req && grant_idx == SLOT) & ~flush_now;
                    if (flush_now) begin
                        valid_reg <= 1'b0;
                    end else if (fill_keep && last_reg == SLOT) begin
                        valid_reg <= 1'b1;
                        tag_reg   <= req_addr_reg;
                        data_reg  <= bus.sdram_dout;
                    end
                end
            end
        end
    endgenerate

    // First eligible slot after the last one granted; scanning backwards leaves the nearest one.
    always_comb begin
        logic [1:0] cand;
        cand      = last_reg;
        grant_any = 1'b0;
        grant_idx = last_reg;
        for (int k = 4; k >= 1; k--) begin
            cand = last_reg + 2'(k);
            if (eligible[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign grant_addr = bus.slot_addr[grant_idx*AW +: AW];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (grant_any) state_next = WAIT_ACK;
            WAIT_ACK: if (bus.sdram_ack) state_next = bus.sdram_rdy ? IDLE : WAIT_RDY;
            WAIT_RDY: if (bus.sdram_rdy) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        load_req = 1'b0;
        fill_en  = 1'b0;
        rd_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                load_req = grant_any;
                rd_next  = grant_any;
            end
            WAIT_ACK: begin
                rd_next = ~bus.sdram_ack;
                fill_en = bus.sdram_ack & bus.sdram_rdy;
            end
            WAIT_RDY: fill_en = bus.sdram_rdy;
            default: ;
        endcase
    end

    // The bank address and the fill tag are the same latched request address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdram_rd_reg <= 1'b0;
            req_addr_reg <= '0;
            last_reg     <= 2'd3;
        end else begin
            sdram_rd_reg <= rd_next;
            if (load_req) begin
                req_addr_reg <= grant_addr;
                last_reg     <= grant_idx;
            end
        end
    end

    assign bus.sdram_rd   = sdram_rd_reg;
    assign bus.sdram_addr = req_addr_reg;
endmodule

// File: tb/tb_jtframe_bank_arbiter.sv
// Self-checking bench for jtframe_bank_arbiter: directed scenarios plus randomized slot traffic.
// Build with JTFRAME_BANK_ARB_FLUSH_EN defined to also exercise the flush input.
module tb_jtframe_bank_arbiter;
    localparam int AW = 22;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef JTFRAME_BANK_ARB_FLUSH_EN
    logic flush = 1'b0;
`endif

    jtframe_bank_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    jtframe_bank_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef JTFRAME_BANK_ARB_FLUSH_EN
        .flush (flush),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents seen through the controller
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a == 22'h100) return 32'hDEADBEEF;
        return {a[9:0], a} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            hit;
        int            t0;
    } exp_t;

    exp_t          exp_q[4][$];
    int            txn_id[4];
    int            done_id[4];
    int            ok_cyc[4];
    logic [AW-1:0] cache_m[4];
    bit            cache_v[4];

    task automatic issue(input int n, input logic [AW-1:0] a);
        exp_t e;
        e.addr = a;
        e.data = mem(a);
        e.hit  = cache_v[n] && cache_m[n] == a;
        e.t0   = cyc;
        bus.slot_addr[n*AW +: AW] = a;
        bus.slot_cs[n] = 1'b1;
        exp_q[n].push_back(e);
        txn_id[n]++;
        $display("issue  slot%0d addr=%06h expect_%s", n, a, e.hit ? "hit" : "miss");
    endtask

    task automatic wait_done(input int n);
        int k;
        k = 0;
        while (done_id[n] != txn_id[n] && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_id[n] != txn_id[n]) check($sformatf("timeout_slot%0d", n), 64'(done_id[n]), 64'(txn_id[n]));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int n = 0; n < 4; n++) begin
                    if (bus.slot_ok[n]) check($sformatf("ok_needs_cs%0d", n), 64'(bus.slot_cs[n]), 64'd1);
                    if (bus.slot_ok[n] && txn_id[n] != done_id[n]) begin
                        if (exp_q[n].size() == 0) begin
                            check($sformatf("unexpected_ok%0d", n), 64'(exp_q[n].size()), 64'd1);
                        end else begin
                            exp_t e;
                            int   lat;
                            e   = exp_q[n].pop_front();
                            lat = cyc - e.t0;
                            check($sformatf("dout_slot%0d", n), 64'(bus.slot_dout[n*DW +: DW]), 64'(e.data));
                            if (e.hit) check($sformatf("hit_latency%0d", n), 64'(lat), 64'd0);
                            else       check($sformatf("miss_latency_ge4_%0d", n), 64'(lat >= 4), 64'd1);
                            $display("ok     slot%0d addr=%06h data=%08h latency=%0d", n, e.addr,
                                     bus.slot_dout[n*DW +: DW], lat);
                            cache_m[n] = e.addr;
                            cache_v[n] = 1'b1;
                        end
                        ok_cyc[n]  = cyc;
                        done_id[n] = txn_id[n];
                    end
                end
            end
        end
    end

    // ---------------- SDRAM bank controller model ----------------
    int            ack_dly   = 2;
    int            rdy_dly   = 4;
    bit            rand_mode = 1'b0;
    bit            ctrl_en   = 1'b1;
    int            rdy_cyc   = 0;
    logic [AW-1:0] req_log[$];

    initial begin
        logic [AW-1:0] a;
        int ad, rdd;
        bus.sdram_ack  = 1'b0;
        bus.sdram_rdy  = 1'b0;
        bus.sdram_dout = '0;
        forever begin
            @(negedge clk);
            if (ctrl_en && !rst && bus.sdram_rd) begin
                a = bus.sdram_addr;
                req_log.push_back(a);
                ad  = rand_mode ? int'($urandom_range(1, 3)) : ack_dly;
                rdd = rand_mode ? ad + int'($urandom_range(0, 3)) : rdy_dly;
                $display("sdram  rd addr=%06h ack+%0d rdy+%0d", a, ad, rdd);
                for (int c = 1; c <= rdd; c++) begin
                    @(posedge clk); #1;
                    bus.sdram_ack  = (c == ad);
                    bus.sdram_rdy  = (c == rdd);
                    bus.sdram_dout = (c == rdd) ? mem(a) : $urandom;
                    if (c == rdd) rdy_cyc = cyc;
                end
                @(posedge clk); #1;
                bus.sdram_ack  = 1'b0;
                bus.sdram_rdy  = 1'b0;
                bus.sdram_dout = $urandom;
                check("rd_low_after_fill", 64'(bus.sdram_rd), 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_model();
        for (int n = 0; n < 4; n++) begin
            exp_q[n].delete();
            done_id[n] = txn_id[n];
            cache_v[n] = 1'b0;
        end
        req_log.delete();
    endtask

    task automatic do_reset();
        bus.slot_cs = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clear_model();
    endtask

    task automatic wait_rd();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.sdram_rd && k < 100);
        check("wait_rd", 64'(bus.sdram_rd), 64'd1);
    endtask

    int exp_misses = 0;

    task automatic slot_proc(input int n);
        logic [AW-1:0] a;
        for (int i = 0; i < 25; i++) begin
            a = AW'(n * 256 + int'($urandom_range(0, 3)));
            if (!(cache_v[n] && cache_m[n] == a)) exp_misses++;
            issue(n, a);
            wait_done(n);
            if ($urandom_range(0, 1) == 1) begin
                bus.slot_cs[n] = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus.slot_cs[n] = 1'b0;
    endtask

    initial begin
        int n0;
        bus.slot_addr = '0;
        bus.slot_cs   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd", 64'(bus.sdram_rd), 64'd0);
        check("rst_addr", 64'(bus.sdram_addr), 64'd0);
        check("rst_ok", 64'(bus.slot_ok), 64'd0);
        for (int n = 0; n < 4; n++) check($sformatf("rst_dout%0d", n), 64'(bus.slot_dout[n*DW +: DW]), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // single miss, then a hit on the same word
        issue(0, 22'h100);
        wait_done(0);
        check("t1_req_count", 64'(req_log.size()), 64'd1);
        check("t1_req_addr", 64'(req_log[0]), 64'h100);
        check("t1_ok_after_rdy", 64'(ok_cyc[0]), 64'(rdy_cyc + 1));
        bus.slot_cs[0] = 1'b0;
        @(posedge clk); #1;
        issue(0, 22'h100);
        wait_done(0);
        check("t2_no_new_rd", 64'(req_log.size()), 64'd1);

        // all four slots miss together
        do_reset();
        for (int n = 0; n < 4; n++) issue(n, AW'(16 * (n + 1)));
        for (int n = 0; n < 4; n++) wait_done(n);
        check("t3_req_count", 64'(req_log.size()), 64'd4);
        for (int n = 0; n < 4; n++) check($sformatf("t3_grant%0d", n), 64'(req_log[n]), 64'(16 * (n + 1)));
        bus.slot_cs = '0;

        // slot1 address moves while its fetch waits for rdy
        do_reset();
        ack_dly = 1;
        rdy_dly = 6;
        issue(1, 22'h20);
        wait_rd();
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_q[1].delete();
        issue(1, 22'h24);
        wait_done(1);
        check("t4_req_count", 64'(req_log.size()), 64'd2);
        check("t4_req0", 64'(req_log[0]), 64'h20);
        check("t4_req1", 64'(req_log[1]), 64'h24);

        // reset while WAIT_ACK; slot1 still hitting on 0x24
        ack_dly = 2;
        rdy_dly = 4;
        ctrl_en = 1'b0;
        issue(2, 22'h50);
        wait_rd();
        #2 rst = 1'b1;
        #1;
        check("t5_rd_async", 64'(bus.sdram_rd), 64'd0);
        check("t5_ok_async", 64'(bus.slot_ok), 64'd0);
        check("t5_addr_async", 64'(bus.sdram_addr), 64'd0);
        bus.slot_cs = '0;
        clear_model();
        @(posedge clk); #1 rst = 1'b0;
        ctrl_en = 1'b1;
        issue(3, 22'h70);
        issue(1, 22'h60);
        wait_done(1);
        wait_done(3);
        check("t5_first_after_rst", 64'(req_log[0]), 64'h60);
        check("t5_second_after_rst", 64'(req_log[1]), 64'h70);
        bus.slot_cs = '0;

`ifdef JTFRAME_BANK_ARB_FLUSH_EN
        do_reset();
        issue(2, 22'h30);
        wait_done(2);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        check("t6_flush_drops_ok", 64'(bus.slot_ok[2]), 64'd0);
        n0 = req_log.size();
        cache_v[2] = 1'b0;
        issue(2, 22'h30);
        wait_done(2);
        check("t6_refetch", 64'(req_log.size()), 64'(n0 + 1));
        n0 = req_log.size();
        issue(2, 22'h38);
        wait_rd();
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_done(2);
        check("t6_inflight_discarded", 64'(req_log.size()), 64'(n0 + 2));
        bus.slot_cs = '0;
`else
        n0 = 0;
`endif

        // randomized traffic on all slots with random controller timing
        do_reset();
        rand_mode  = 1'b1;
        exp_misses = 0;
        for (int n = 0; n < 4; n++) begin
            automatic int s = n;
            fork
                slot_proc(s);
            join_none
        end
        wait fork;
        repeat (3) @(posedge clk);
        #1;
        check("rand_req_count", 64'(req_log.size()), 64'(exp_misses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit, required $finish earlier");
        $fatal(1, "watchdog");
    end
endmodule
